// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the shared RAM1/UART bus: an instruction-fetch port and
// a data port.  Grants are combinational and are latched into a one-cycle
// access stage that drives the bus.  The data port has priority.  Defining
// MEM_BUS_ARBITER_FAIR_EN adds a run counter that lets a waiting fetch in after
// MAX_DATA_RUN back-to-back data grants.
module mem_bus_arbiter #(
    parameter int MAX_DATA_RUN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic        if_gnt,
    output logic        mem_gnt,
    output logic        if_ack,
    output logic        mem_ack,
    output logic [15:0] rdata_o,
    output logic [17:0] bus_addr_o,
    output logic [15:0] bus_wdata_o,
    output logic        bus_isread_o,
    output logic        bus_iswrite_o,
    output logic        bus_is_ram1_o,
    output logic        bus_is_uart_o,
    input  logic [15:0] ram_rdata_i,
    output logic        if_stall_o,
    output logic        mem_stall_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_I = 2'd1,
        ACC_D = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] acc_addr;
    logic [15:0] acc_wdata;
    logic        acc_write;
    logic        grant_if;
    logic        grant_mem;
    logic        acc_active;
    logic        uart_sel;

    // The run counter is 3 bits wide, so the limit must fit in it.
    if (MAX_DATA_RUN < 1 || MAX_DATA_RUN > 7) begin : g_bad_max_data_run
        $error("mem_bus_arbiter: MAX_DATA_RUN must be in 1..7");
    end

`ifdef MEM_BUS_ARBITER_FAIR_EN
    logic [2:0] data_run;
    logic       run_full;

    assign run_full = if_req && (data_run == 3'(MAX_DATA_RUN));

    // Data wins unless a fetch has already waited through a full run of data grants.
    always_comb begin
        grant_mem = !rst && mem_req && !run_full;
        grant_if  = !rst && if_req && !grant_mem;
    end

    // Count data grants made while a fetch waits; restart whenever the fetch is served or withdrawn.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_run <= 3'd0;
        end else if (!if_req || grant_if) begin
            data_run <= 3'd0;
        end else if (grant_mem) begin
            data_run <= data_run + 3'd1;
        end
    end
`else
    // Strict data priority; a fetch only gets the bus when the data port is quiet.
    always_comb begin
        grant_mem = !rst && mem_req;
        grant_if  = !rst && if_req && !mem_req;
    end
`endif

    assign if_gnt      = grant_if;
    assign mem_gnt     = grant_mem;
    assign if_stall_o  = if_req && !grant_if;
    assign mem_stall_o = mem_req && !grant_mem;

    // State register for the access stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next access is whatever was granted this cycle, regardless of the current access.
    always_comb begin
        next_state = IDLE;
        if (grant_mem) begin
            next_state = ACC_D;
        end else if (grant_if) begin
            next_state = ACC_I;
        end
    end

    // Latch the granted request; address and write data hold while idle, and a fetch leaves write data untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_addr  <= 16'h0000;
            acc_wdata <= 16'h0000;
            acc_write <= 1'b0;
        end else if (grant_mem) begin
            acc_addr  <= mem_addr;
            acc_wdata <= mem_wdata;
            acc_write <= mem_we;
        end else if (grant_if) begin
            acc_addr  <= if_addr;
            acc_write <= 1'b0;
        end
    end

    // 0xBF00 and 0xBF01 differ only in bit 0, so compare the upper 15 bits.
    assign uart_sel   = (acc_addr[15:1] == 15'h5F80);
    assign acc_active = (state != IDLE);

    assign if_ack        = (state == ACC_I);
    assign mem_ack       = (state == ACC_D);
    assign bus_addr_o    = {2'b00, acc_addr};
    assign bus_wdata_o   = acc_wdata;
    assign bus_isread_o  = acc_active && !acc_write;
    assign bus_iswrite_o = acc_active && acc_write;
    assign bus_is_uart_o = acc_active && uart_sel;
    assign bus_is_ram1_o = acc_active && !uart_sel;
    assign rdata_o       = ram_rdata_i;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_RUN, default 3, giving the maximum consecutive data-port grants while a fetch waits (range 1..7).
REQ-002 SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1  reset: one clock, reset synchronous and active-high.
REQ-004 SHALL have ports if_req in 1 and if_addr in 16: instruction-fetch read request and word address.
REQ-005 SHALL have ports mem_req in 1, mem_we in 1, mem_addr in 16 and mem_wdata in 16: data-port request, write flag (1=write), address and write data.
REQ-006 SHALL have ports if_gnt out 1 and mem_gnt out 1: the request is accepted at this rising edge.
REQ-007 SHALL have ports if_ack out 1 and mem_ack out 1: the access is in progress this cycle, and the read data is valid at its closing edge.
REQ-008 SHALL have port rdata_o out 16: read data, a pass-through of ram_rdata_i.
REQ-009 SHALL have ports bus_addr_o out 18, bus_wdata_o out 16, bus_isread_o out 1, bus_iswrite_o out 1, bus_is_ram1_o out 1 and bus_is_uart_o out 1: the shared RAM1/UART bus controls.
REQ-010 SHALL have port ram_rdata_i in 16: read data returned from the RAM1/UART bus.
REQ-011 SHALL have ports if_stall_o out 1 and mem_stall_o out 1: a pipeline freeze equal to req AND NOT gnt for that port.

Function
REQ-012 SHALL operate as a two-stage pipeline: an issue stage (combinational grant, latched at the edge) and an access stage (registered bus controls lasting exactly one cycle).
REQ-013 SHALL grant at most one port per cycle; without the fairness feature, mem_req takes priority over if_req.
REQ-014 SHALL compute gnt combinationally from the current req and fairness state; the requester may change req/addr after any edge at which gnt=1.
REQ-015 SHALL, at an edge with a grant, load the access stage: address, write data, read/write type and port ID; in the following cycle it SHALL assert the matching ack for exactly one cycle.
REQ-016 SHALL sustain one access per cycle back to back, including the same port in consecutive cycles.
REQ-017 SHALL treat an IF access as a read; a data access is a write when mem_we=1 and a read otherwise.
REQ-018 SHALL, during an access cycle, drive bus_addr_o={2'b00,addr}, bus_isread_o=!write, bus_iswrite_o=write and bus_wdata_o=the latched write data.
REQ-019 SHALL decode addresses 0xBF00 and 0xBF01 to bus_is_uart_o=1, bus_is_ram1_o=0, and all other addresses to bus_is_ram1_o=1, bus_is_uart_o=0.
REQ-020 SHALL, in an idle cycle (no access), drive bus_isread_o, bus_iswrite_o, bus_is_ram1_o, bus_is_uart_o and both acks to 0, and hold bus_addr_o/bus_wdata_o at their last values.
REQ-021 SHALL place the FSM in one of three states: IDLE, ACC_I or ACC_D; the next state is ACC_D if the data port is granted, ACC_I if the fetch port is granted, else IDLE, from any state.
REQ-022 SHALL drive rdata_o=ram_rdata_i at all times; the requester samples it at the edge closing its ack cycle.

Reset
REQ-023 SHALL, while rst=1 at an edge, go to state IDLE, clear the fairness counter, set all acks and bus strobes/selects to 0, and set bus_addr_o and bus_wdata_o to 0.
REQ-024 SHALL force if_gnt=mem_gnt=0 while rst=1; an access in flight when reset is asserted SHALL be dropped with no ack.

Configuration
REQ-025 SHALL compile in the fairness logic only when macro MEM_BUS_ARBITER_FAIR_EN is defined.
REQ-026 SHALL, with MEM_BUS_ARBITER_FAIR_EN defined, keep a 3-bit counter of consecutive data grants made while if_req=1.
REQ-027 SHALL, with the macro defined and the counter at MAX_DATA_RUN and if_req=1, grant IF instead of data.
REQ-028 SHALL, with the macro defined, clear the counter on any IF grant or any cycle with if_req=0.
REQ-029 SHALL, without the macro, give strict data priority, and if_req may starve indefinitely.

Verification
REQ-030 SHALL pass: if_req alone, if_addr=0x0040, held 3 cycles -> if_gnt=1 each cycle; if_ack on cycles 2..4 with bus_addr_o=0x00040, bus_isread_o=1, bus_is_ram1_o=1.
REQ-031 SHALL pass: if_req and mem_req (write 0x1234 to 0x8000) asserted together -> mem_gnt=1, if_stall_o=1, bus_iswrite_o=1, bus_wdata_o=0x1234; if_gnt follows one cycle later.
REQ-032 SHALL pass: mem read at 0xBF01 -> bus_is_uart_o=1, bus_is_ram1_o=0; ram_rdata_i=0x0003 is returned on rdata_o during mem_ack.
REQ-033 SHALL pass with FAIR_EN: mem_req and if_req held high -> pattern of 3 data grants, 1 IF grant, repeating; without FAIR_EN -> if_gnt never asserts.
REQ-034 SHALL pass: rst raised during an ACC_D cycle -> at the next cycle all acks=0, strobes=0 and state IDLE, and no grant is made while rst=1.
